// File: rtl/var_bit_packer.sv
// Variable-length bit packer: MSB-first fields of 0..IN_W bits are packed into
// OUT_W-bit words; frame end flushes a zero-padded word tagged with last_o.
module var_bit_packer #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [IN_W-1:0]              data_i,
  input  logic [$clog2(IN_W+1)-1:0]    len_i,
  input  logic                         last_i,
  input  logic                         vld_i,
  output logic                         rdy_o,
  output logic [OUT_W-1:0]             data_o,
  output logic [$clog2(OUT_W+1)-1:0]   nbits_o,
  output logic                         last_o,
  output logic                         vld_o,
  input  logic                         rdy_i,
  output logic                         idle_o
);
  localparam int BUF_W = IN_W + OUT_W;
  localparam int CW    = $clog2(BUF_W + 1);
  localparam int NW    = $clog2(OUT_W + 1);
  localparam logic [CW-1:0] OUT_C = CW'(OUT_W);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t           st_q, st_d;
  logic [BUF_W-1:0] buf_q, buf_d, buf_pop_s, field_s;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_pop_s;
  logic [IN_W-1:0]  mask_s;
  logic             pop_s, push_s;

  assign vld_o     = ((st_q == FILL) && (cnt_q >= OUT_C)) || (st_q == FLUSH);
  assign pop_s     = vld_o & rdy_i;
  assign buf_pop_s = pop_s ? (buf_q << OUT_W) : buf_q;
  assign cnt_pop_s = pop_s ? ((cnt_q >= OUT_C) ? (cnt_q - OUT_C) : '0) : cnt_q;
  // Accepting only while at most OUT_W bits remain guarantees IN_W bits of room.
  assign rdy_o     = (st_q != FLUSH) && (cnt_pop_s <= OUT_C);
  assign push_s    = vld_i & rdy_o;
  assign mask_s    = ~({IN_W{1'b1}} >> len_i);
  assign field_s   = {data_i & mask_s, {OUT_W{1'b0}}} >> cnt_pop_s;

  assign data_o  = buf_q[BUF_W-1 -: OUT_W];
  assign nbits_o = vld_o ? ((cnt_q >= OUT_C) ? NW'(OUT_W) : cnt_q[NW-1:0]) : '0;
  assign last_o  = (st_q == FLUSH) && (cnt_q <= OUT_C);
  assign idle_o  = (st_q == IDLE) && (cnt_q == '0) && !push_s;

  // Next-state, buffer and occupancy update (pop first, then append the field)
  always_comb begin
    st_d  = st_q;
    buf_d = buf_pop_s;
    cnt_d = cnt_pop_s;
    if (push_s) begin
      buf_d = buf_pop_s | field_s;
      cnt_d = cnt_pop_s + CW'(len_i);
    end else begin
      buf_d = buf_pop_s;
      cnt_d = cnt_pop_s;
    end
    case (st_q)
      IDLE: begin
        if (push_s) st_d = last_i ? FLUSH : FILL;
        else        st_d = IDLE;
      end
      FILL: begin
        if (push_s && last_i)           st_d = FLUSH;
        else if (!push_s && cnt_d == '0) st_d = IDLE;
        else                            st_d = FILL;
      end
      FLUSH: begin
        if (pop_s && (cnt_q <= OUT_C)) begin
          st_d  = IDLE;
          buf_d = '0;
          cnt_d = '0;
        end else begin
          st_d = FLUSH;
        end
      end
      default: begin
        st_d  = IDLE;
        buf_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q  <= IDLE;
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  var_bit_packer_chk #(.IN_W(IN_W), .OUT_W(OUT_W)) u_chk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .idle_st(st_q == IDLE),
    .buf_q  (buf_q),
    .cnt_q  (cnt_q),
    .vld_i  (vld_i),
    .len_i  (len_i)
  );
endmodule

// Simulation-only invariants of the packer state.
module var_bit_packer_chk #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input logic                                clk_i,
  input logic                                rst_i,
  input logic                                idle_st,
  input logic [IN_W+OUT_W-1:0]               buf_q,
  input logic [$clog2(IN_W+OUT_W+1)-1:0]     cnt_q,
  input logic                                vld_i,
  input logic [$clog2(IN_W+1)-1:0]           len_i
);
  localparam int BUF_W = IN_W + OUT_W;
  localparam int CW    = $clog2(BUF_W + 1);
  localparam int LW    = $clog2(IN_W + 1);

  // Occupancy bound, zero tail below cnt_q, empty IDLE, legal field length
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (cnt_q <= CW'(BUF_W));
      assert ((buf_q & ({BUF_W{1'b1}} >> cnt_q)) == '0);
      assert (!idle_st || (cnt_q == '0));
      assert (!vld_i || (len_i <= LW'(IN_W)));
    end
  end
endmodule

// File: tb/tb_var_bit_packer.sv
// Self-checking bench for var_bit_packer (IN_W=16, OUT_W=8): table-driven frames
// with a word scoreboard, plus hand sequences for flush, stall and reset.
module tb_var_bit_packer;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic [4:0]  len_i = '0;
  logic        last_i = 1'b0, vld_i = 1'b0, rdy_i = 1'b1;
  logic        rdy_o, last_o, vld_o, idle_o;
  logic [7:0]  data_o;
  logic [3:0]  nbits_o;

  always #5 clk = ~clk;

  var_bit_packer #(.IN_W(16), .OUT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .len_i(len_i),
    .last_i(last_i), .vld_i(vld_i), .rdy_o(rdy_o), .data_o(data_o),
    .nbits_o(nbits_o), .last_o(last_o), .vld_o(vld_o), .rdy_i(rdy_i),
    .idle_o(idle_o)
  );

  typedef struct packed {logic [7:0] d; logic [3:0] n; logic l;} word_t;
  typedef struct {
    logic [15:0] d; logic [4:0] len; logic last; int nw; word_t w [3];
  } vec_t;

  word_t sb [$];
  vec_t  tbl [12];
  int    errors = 0, checks = 0, cyc = 0, npop = 0;
  logic  rnd_mode = 1'b0;

  function automatic word_t w(input logic [7:0] d, input logic [3:0] n, input logic l);
    word_t r;
    r.d = d; r.n = n; r.l = l;
    return r;
  endfunction

  function automatic vec_t mk(input logic [15:0] d, input logic [4:0] len, input logic last,
                              input int nw, input word_t w0, input word_t w1, input word_t w2);
    vec_t v;
    v.d = d; v.len = len; v.last = last; v.nw = nw;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Random output back-pressure when enabled
  initial forever begin
    @(negedge clk);
    if (rnd_mode) rdy_i = 1'($urandom_range(0, 1));
  end

  // Scoreboard monitor: samples the handshake between edges
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_i && vld_o && rdy_i) begin
        npop++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h/%0d/%0b, expected none", data_o, nbits_o, last_o);
        end else begin
          e = sb.pop_front();
          chk("out_word{data,nbits,last}", 32'({data_o, nbits_o, last_o}), 32'(e));
        end
      end
    end
  end

  // Drive one beat (called at a falling edge); expected words queued on acceptance
  task automatic send(input vec_t v);
    int n = 0;
    bit done = 0;
    data_i = v.d; len_i = v.len; last_i = v.last; vld_i = 1'b1;
    while (!done) begin
      #2;
      if (rdy_o) begin
        for (int k = 0; k < v.nw; k++) sb.push_back(v.w[k]);
        done = 1;
      end else if (n >= 300) begin
        checks++; errors++;
        $display("FAIL send_timeout: rdy_o stuck at 0, expected 1");
        done = 1;
      end
      n++;
      @(negedge clk);
    end
    vld_i = 1'b0; data_i = '0; len_i = '0; last_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    #2;
    while ((sb.size() != 0 || !idle_o) && n < 500) begin
      @(negedge clk); #2; n++;
    end
    chk(name, 32'(sb.size() == 0 && idle_o), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, p0;
    word_t z;
    z = '0;
    tbl[0]  = mk(16'hB000, 5'd5,  1'b0, 0, z, z, z);
    tbl[1]  = mk(16'h6800, 5'd5,  1'b0, 1, w(8'hB3, 4'd8, 1'b0), z, z);
    tbl[2]  = mk(16'hABFF, 5'd12, 1'b1, 2, w(8'h6A, 4'd8, 1'b0), w(8'hFC, 4'd6, 1'b1), z);
    tbl[3]  = mk(16'hABFF, 5'd12, 1'b1, 2, w(8'hAB, 4'd8, 1'b0), w(8'hF0, 4'd4, 1'b1), z);
    tbl[4]  = mk(16'h0000, 5'd0,  1'b1, 1, w(8'h00, 4'd0, 1'b1), z, z);
    tbl[5]  = mk(16'hFFFF, 5'd3,  1'b0, 0, z, z, z);
    tbl[6]  = mk(16'h1234, 5'd0,  1'b0, 0, z, z, z);
    tbl[7]  = mk(16'h5555, 5'd7,  1'b0, 1, w(8'hEA, 4'd8, 1'b0), z, z);
    tbl[8]  = mk(16'hC3FF, 5'd16, 1'b1, 3, w(8'hB0, 4'd8, 1'b0), w(8'hFF, 4'd8, 1'b0), w(8'hC0, 4'd2, 1'b1));
    tbl[9]  = mk(16'h8000, 5'd1,  1'b1, 1, w(8'h80, 4'd1, 1'b1), z, z);
    tbl[10] = mk(16'h00FF, 5'd8,  1'b0, 1, w(8'h00, 4'd8, 1'b0), z, z);
    tbl[11] = mk(16'hFF00, 5'd8,  1'b1, 1, w(8'hFF, 4'd8, 1'b1), z, z);

    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("reset_rdy_o", 32'(rdy_o), 32'd1);
    chk("reset_vld_o", 32'(vld_o), 32'd0);
    chk("reset_idle_o", 32'(idle_o), 32'd1);
    chk("reset_data_o", 32'(data_o), 32'h0);
    chk("reset_nbits_o", 32'(nbits_o), 32'd0);
    chk("reset_last_o", 32'(last_o), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 12; i++) send(tbl[i]);
    wait_drain("table_drain");

    // 12-bit frame from idle: two words, rdy_o low until the last pop
    send(tbl[3]);
    #2;
    chk("flush1_vld_o", 32'(vld_o), 32'd1);
    chk("flush1_rdy_o", 32'(rdy_o), 32'd0);
    chk("flush1_data_o", 32'(data_o), 32'hAB);
    @(negedge clk); #2;
    chk("flush2_last_o", 32'(last_o), 32'd1);
    chk("flush2_nbits_o", 32'(nbits_o), 32'd4);
    chk("flush2_rdy_o", 32'(rdy_o), 32'd0);
    @(negedge clk); #2;
    chk("flush_done_idle_o", 32'(idle_o), 32'd1);
    chk("flush_done_rdy_o", 32'(rdy_o), 32'd1);
    @(negedge clk);

    // Empty frame from idle
    send(tbl[4]);
    #2;
    chk("empty_vld_o", 32'(vld_o), 32'd1);
    chk("empty_last_o", 32'(last_o), 32'd1);
    chk("empty_nbits_o", 32'(nbits_o), 32'd0);
    @(negedge clk); #2;
    chk("empty_idle_o", 32'(idle_o), 32'd1);
    @(negedge clk);

    // Continuous 16-bit beats: 64 words at one word per cycle
    c0 = cyc; p0 = npop;
    for (int i = 0; i < 32; i++)
      send(mk(16'hABCD, 5'd16, 1'b0, 2, w(8'hAB, 4'd8, 1'b0), w(8'hCD, 4'd8, 1'b0), z));
    wait_drain("stream_drain");
    chk("stream_word_count", 32'(npop - p0), 32'd64);
    chk("stream_throughput", 32'((cyc - c0) <= 70), 32'd1);

    rnd_mode = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 12; i++) send(tbl[i]);
    rnd_mode = 1'b0;
    rdy_i = 1'b1;
    wait_drain("random_drain");

    // Stall with 16 bits buffered in FLUSH, then reset mid-flush
    rdy_i = 1'b0;
    send(mk(16'hABCD, 5'd16, 1'b1, 2, w(8'hAB, 4'd8, 1'b0), w(8'hCD, 4'd8, 1'b1), z));
    for (int k = 0; k < 10; k++) begin
      #2;
      chk("stall_data_o", 32'(data_o), 32'hAB);
      chk("stall_vld_o", 32'(vld_o), 32'd1);
      chk("stall_rdy_o", 32'(rdy_o), 32'd0);
      chk("stall_last_o", 32'(last_o), 32'd0);
      @(negedge clk);
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #2;
    chk("rst_flush_vld_o", 32'(vld_o), 32'd0);
    chk("rst_flush_rdy_o", 32'(rdy_o), 32'd1);
    chk("rst_flush_last_o", 32'(last_o), 32'd0);
    chk("rst_flush_nbits_o", 32'(nbits_o), 32'd0);
    chk("rst_flush_data_o", 32'(data_o), 32'h0);
    chk("rst_flush_idle_o", 32'(idle_o), 32'd1);
    sb.delete();
    rdy_i = 1'b1;
    @(negedge clk);

    send(tbl[3]);
    wait_drain("post_reset_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
